// File: rtl/mult_div_pkg.sv
// Shared constants and FSM encoding for the iterative multiply/divide unit.
// MULTDIV_RADIX4_MULT_EN selects a 2-bit-per-step multiply.
package mult_div_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CNT_W = 6;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MULT,
      S_DIV,
      S_FIX
   } state_e;

`ifdef MULTDIV_RADIX4_MULT_EN
   localparam int MULT_ITERS = DEF_WIDTH / 2;
`else
   localparam int MULT_ITERS = DEF_WIDTH;
`endif
   localparam int DIV_ITERS = DEF_WIDTH;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in a dividend bit, subtract if it fits.
module div_restore_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] rem_i,
   input  logic [W-1:0] divisor_i,
   input  logic         din_i,
   output logic [W-1:0] rem_o,
   output logic         q_o
);

   logic [W:0] trial;
   logic [W:0] diff;

   assign trial = {rem_i, din_i};
   assign diff  = trial - {1'b0, divisor_i};
   // rem < divisor always holds, so a clear top bit means no borrow
   assign q_o   = ~diff[W];
   assign rem_o = q_o ? diff[W-1:0] : trial[W-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply / divide writing HI/LO on completion.
// MULTDIV_RADIX4_MULT_EN: multiply retires 2 bits per cycle.
module mult_div_unit
   import mult_div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             multOP,
   input  logic             divOP,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             divByZero
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   bmag_q, bmag_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               sa_q, sa_d;
   logic               sb_q, sb_d;
   logic               div_q, div_d;
   logic               done_q, done_d;
   logic               dbz_q, dbz_d;

   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [2*WIDTH-1:0] m_next, d_next, prod;
   logic [WIDTH-1:0]   rem_n, quo, rem;
   logic               q_bit;

   assign a_abs = srcA[WIDTH-1] ? -srcA : srcA;
   assign b_abs = srcB[WIDTH-1] ? -srcB : srcB;

`ifdef MULTDIV_RADIX4_MULT_EN
   logic [WIDTH+1:0] b_x, m_sum;

   always_comb begin
      b_x = '0;
      unique case (acc_q[1:0])
         2'd1:    b_x = {2'b00, bmag_q};
         2'd2:    b_x = {1'b0, bmag_q, 1'b0};
         2'd3:    b_x = {1'b0, bmag_q, 1'b0} + {2'b00, bmag_q};
         default: b_x = '0;
      endcase
      m_sum  = {2'b00, acc_q[2*WIDTH-1:WIDTH]} + b_x;
      m_next = {m_sum, acc_q[WIDTH-1:2]};
   end
`else
   logic [WIDTH:0] m_sum;

   always_comb begin
      m_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
             + (acc_q[0] ? {1'b0, bmag_q} : '0);
      m_next = {m_sum, acc_q[WIDTH-1:1]};
   end
`endif

   // Divide reuses acc: upper half is remainder, lower half shifts quotient in
   div_restore_step #(.W(WIDTH)) u_step (
      .rem_i     (acc_q[2*WIDTH-1:WIDTH]),
      .divisor_i (bmag_q),
      .din_i     (acc_q[WIDTH-1]),
      .rem_o     (rem_n),
      .q_o       (q_bit)
   );

   assign d_next = {rem_n, acc_q[WIDTH-2:0], q_bit};
   assign prod   = (sa_q ^ sb_q) ? -acc_q : acc_q;
   assign quo    = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem    = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      bmag_d  = bmag_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      div_d   = div_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dbz_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (multOP || (divOP && srcB != '0)) begin
               state_d = multOP ? S_MULT : S_DIV;
               div_d   = ~multOP;
               acc_d   = {{WIDTH{1'b0}}, a_abs};
               bmag_d  = b_abs;
               sa_d    = srcA[WIDTH-1];
               sb_d    = srcB[WIDTH-1];
               cnt_d   = '0;
            end else if (divOP) begin
               dbz_d = 1'b1;
            end
         end
         S_MULT: begin
            acc_d = m_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(MULT_ITERS - 1)) state_d = S_FIX;
         end
         S_DIV: begin
            acc_d = d_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DIV_ITERS - 1)) state_d = S_FIX;
         end
         S_FIX: begin
            if (div_q) begin
               hi_d = rem;
               lo_d = quo;
            end else begin
               {hi_d, lo_d} = prod;
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         bmag_q  <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         div_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         bmag_q  <= bmag_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         div_q   <= div_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
      end
   end

   assign hi        = hi_q;
   assign lo        = lo_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign divByZero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit against a plain-arithmetic model.
// Honours MULTDIV_RADIX4_MULT_EN for the expected multiply latency.
module tb_mult_div_unit;

   typedef struct packed {
      logic        dz;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

`ifdef MULTDIV_RADIX4_MULT_EN
   localparam int MUL_LAT = 17;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        multOP = 1'b0;
   logic        divOP = 1'b0;
   logic [31:0] srcA = '0;
   logic [31:0] srcB = '0;
   logic [31:0] hi, lo;
   logic        busy, done, divByZero;

   int   checks = 0;
   int   failures = 0;
   exp_t sbq[$];
   logic [31:0] mhi = '0;
   logic [31:0] mlo = '0;

   mult_div_unit dut (
      .clk       (clk),
      .reset     (rst_n),
      .multOP    (multOP),
      .divOP     (divOP),
      .srcA      (srcA),
      .srcB      (srcB),
      .hi        (hi),
      .lo        (lo),
      .busy      (busy),
      .done      (done),
      .divByZero (divByZero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input bit is_div, input logic [31:0] a,
                                  input logic [31:0] b);
      exp_t   e;
      longint p, q, r;
      e = '0;
      if (!is_div) begin
         p = longint'($signed(a)) * longint'($signed(b));
         e.hi = p[63:32];
         e.lo = p[31:0];
      end else if (b == 0) begin
         e.dz = 1'b1;
         e.hi = mhi;
         e.lo = mlo;
      end else begin
         q = longint'($signed(a)) / longint'($signed(b));
         r = longint'($signed(a)) % longint'($signed(b));
         e.hi = r[31:0];
         e.lo = q[31:0];
      end
      return e;
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && (done || divByZero)) begin
         if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output done=%b dz=%b", done, divByZero);
         end else begin
            e = sbq.pop_front();
            chk("dz_flag", {31'b0, divByZero}, {31'b0, e.dz});
            chk("done_flag", {31'b0, done}, {31'b0, ~e.dz});
            chk("hi", hi, e.hi);
            chk("lo", lo, e.lo);
         end
      end
   end

   task automatic run_op(input bit is_div, input logic [31:0] a,
                         input logic [31:0] b);
      exp_t e;
      int   n;
      bit   busy_ok;
      e = model(is_div, a, b);
      mhi = e.hi;
      mlo = e.lo;
      sbq.push_back(e);
      multOP = ~is_div;
      divOP  = is_div;
      srcA   = a;
      srcB   = b;
      @(posedge clk);
      #1;
      multOP = 1'b0;
      divOP  = 1'b0;
      if (e.dz) begin
         chk("dz_pulse", {31'b0, divByZero}, 32'd1);
         chk("dz_busy", {31'b0, busy}, 32'd0);
         @(posedge clk);
         #1;
         chk("dz_one_cycle", {31'b0, divByZero}, 32'd0);
         chk("dz_busy_after", {31'b0, busy}, 32'd0);
      end else begin
         n = 0;
         busy_ok = busy;
         while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
            if (!busy) busy_ok = 0;
            multOP = 1'($urandom_range(0, 1));
            divOP  = 1'($urandom_range(0, 1));
            srcA   = $urandom;
            srcB   = $urandom;
         end
         multOP = 1'b0;
         divOP  = 1'b0;
         chk("latency", n, is_div ? DIV_LAT : MUL_LAT);
         chk("busy_during_op", {31'b0, busy_ok}, 32'd1);
         chk("busy_at_done", {31'b0, busy}, 32'd0);
      end
   endtask

   function automatic logic [31:0] pick();
      unique case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_dz", {31'b0, divByZero}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_op(0, 32'h0000_0007, 32'hFFFF_FFFD);
      run_op(0, 32'h8000_0000, 32'h8000_0000);
      run_op(1, 32'hFFFF_FFF9, 32'h0000_0002);
      run_op(1, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(1, 32'h0000_0005, 32'h0000_0000);
      run_op(1, 32'h0000_0064, 32'h0000_0000);

      // abort a multiply with reset; no expectation is queued for it
      multOP = 1'b1;
      srcA   = 32'h1234_5678;
      srcB   = 32'h0000_0099;
      @(posedge clk);
      #1;
      multOP = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      multOP = 1'b1;
      @(posedge clk);
      #1;
      multOP = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("busy_mid_op", {31'b0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd0);
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_done", {31'b0, done}, 32'd0);
      chk("abort_dz", {31'b0, divByZero}, 32'd0);
      mhi = '0;
      mlo = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_op(0, 32'd3, 32'd4);

      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         run_op(1'($urandom_range(0, 1)), pick(), pick());
      end

      n = 0;
      while (sbq.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      repeat (3) @(posedge clk);
      chk("scoreboard_empty", sbq.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
